mem_port_arbiter: RTL and testbench

Sequencer that shares one unified, variable-latency memory port between the instruction fetch unit and the data memory stage of the MIPS core. Each requester runs a req/ack handshake; the arbiter grants one at a time, drives the memory port, returns read data with a one-cycle ack pulse, and aborts accesses the memory never answers. It sits between the IFU/DM request logic and the external memory model, and its outstanding-request status feeds the core's stall logic.

---
 rtl/mem_port_arbiter_pkg.sv | 27 ++
 rtl/mem_wait_timer.sv | 31 +++
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the IFU/DM unified memory port arbiter:
// state encoding, requester ids, abort data and bus widths.
package mem_port_arbiter_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned WAIT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef logic req_id_t;
    localparam req_id_t REQ_FETCH = 1'b0;
    localparam req_id_t REQ_DATA  = 1'b1;

    localparam logic [DATA_W-1:0] ABORT_DATA = 32'h0;

    // Loads always read the full word; stores use the requester's byte enables.
    function automatic logic [BE_W-1:0] data_be(input logic we, input logic [BE_W-1:0] be);
        return we ? be : 4'hF;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-state counter for an outstanding memory access.
// Ports: clk/reset (sync, active-high), clear (restart count), enable
// (count one waiting cycle), expired_c (this waiting cycle is the last one
// allowed, so the access must be aborted at the coming edge).
module mem_wait_timer
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired_c
);

    logic [WAIT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + WAIT_W'(1);
        end
    end

    // Fires on the TIMEOUT-th consecutive waiting cycle so the abort lands
    // at the same edge the count would reach TIMEOUT.
    assign expired_c = enable && (count == WAIT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and
// the data memory stage.
// Ports: if_* fetch req/ack/data, dm_* data req/ack/data, mem_* memory port,
// busy (not idle), bus_err (sticky timeout abort flag). Sync active-high reset.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [BE_W-1:0]   dm_be,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [BE_W-1:0]   mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              bus_err
);

    state_t  state;
    req_id_t gnt;
    req_id_t last_served;
    logic    grant_data_c;
    logic    wait_en_c;
    logic    expired_c;

    // Round-robin on a tie: serve whoever was not served last.
    always_comb begin
        grant_data_c = 1'b0;
        if (if_req && dm_req) begin
            grant_data_c = (last_served == REQ_FETCH);
        end else begin
            grant_data_c = dm_req;
        end
    end

    assign wait_en_c = ((state == FETCH) || (state == DATA)) && !mem_ready;

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clear     (state == IDLE),
        .enable    (wait_en_c),
        .expired_c (expired_c)
    );

    // Sequencer with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            gnt         <= REQ_FETCH;
            last_served <= REQ_FETCH;
            if_ack      <= 1'b0;
            dm_ack      <= 1'b0;
            if_rdata    <= '0;
            dm_rdata    <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_be      <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            busy        <= 1'b0;
            bus_err     <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            dm_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_req || dm_req) begin
                        busy    <= 1'b1;
                        mem_req <= 1'b1;
                        if (grant_data_c) begin
                            gnt       <= REQ_DATA;
                            state     <= DATA;
                            mem_addr  <= dm_addr;
                            mem_we    <= dm_we;
                            mem_be    <= data_be(dm_we, dm_be);
                            mem_wdata <= dm_wdata;
                        end else begin
                            gnt      <= REQ_FETCH;
                            state    <= FETCH;
                            mem_addr <= if_addr;
                            mem_we   <= 1'b0;
                            mem_be   <= 4'hF;
                        end
                    end
                end
                FETCH, DATA: begin
                    // A completion arriving on the last allowed cycle wins over abort.
                    if (mem_ready) begin
                        mem_req     <= 1'b0;
                        state       <= RESP;
                        last_served <= gnt;
                        if (state == FETCH) begin
                            if_rdata <= mem_rdata;
                        end else if (!mem_we) begin
                            dm_rdata <= mem_rdata;
                        end
                    end else if (expired_c) begin
                        mem_req     <= 1'b0;
                        state       <= RESP;
                        last_served <= gnt;
                        bus_err     <= 1'b1;
                        if (state == FETCH) begin
                            if_rdata <= ABORT_DATA;
                        end else begin
                            dm_rdata <= ABORT_DATA;
                        end
                    end
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (gnt == REQ_FETCH) begin
                        if_ack <= 1'b1;
                    end else begin
                        dm_ack <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized traffic, checked against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        bus_err;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state (transaction level).
    logic        m_last_dm;
    logic [31:0] m_if_rdata;
    logic [31:0] m_dm_rdata;
    logic        m_bus_err;

    mem_port_arbiter #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_be     (dm_be),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_ack    (dm_ack),
        .dm_rdata  (dm_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_last_dm  = 1'b0;
        m_if_rdata = 32'h0;
        m_dm_rdata = 32'h0;
        m_bus_err  = 1'b0;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        if_req    = 1'b0;
        dm_req    = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        tick();
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    task automatic idle_checks(input string tag);
        chk({tag, "_acks"}, {30'h0, if_ack, dm_ack}, 32'h0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_mem_req"}, mem_req, 1'b0);
        chk({tag, "_if_rdata"}, if_rdata, m_if_rdata);
        chk({tag, "_dm_rdata"}, dm_rdata, m_dm_rdata);
        chk({tag, "_bus_err"}, bus_err, m_bus_err);
    endtask

    // One memory access: called with requests already driven and the arbiter
    // idle. d = wait cycles before mem_ready (d >= TIMEOUT means never).
    task automatic access(input int d, input logic [31:0] rd);
        logic        win_dm;
        logic        exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        bit          done;
        bit          aborted;
        int          k;
        win_dm    = (if_req && dm_req) ? !m_last_dm : dm_req;
        exp_addr  = win_dm ? dm_addr : if_addr;
        exp_we    = win_dm && dm_we;
        exp_be    = exp_we ? dm_be : 4'hF;
        exp_wdata = dm_wdata;
        tick();
        chk("grant_mem_req", mem_req, 1'b1);
        chk("grant_busy", busy, 1'b1);
        k       = 0;
        done    = 1'b0;
        aborted = 1'b0;
        while (!done) begin
            chk("mem_addr", mem_addr, exp_addr);
            chk("mem_we", mem_we, exp_we);
            chk("mem_be", mem_be, exp_be);
            if (exp_we) chk("mem_wdata", mem_wdata, exp_wdata);
            chk("no_early_ack", {30'h0, if_ack, dm_ack}, 32'h0);
            mem_ready = (k == d);
            mem_rdata = (k == d) ? rd : $urandom;
            tick();
            k++;
            mem_ready = 1'b0;
            if (d < int'(TIMEOUT) && k == d + 1) begin
                done = 1'b1;
            end else if (k == int'(TIMEOUT)) begin
                done    = 1'b1;
                aborted = 1'b1;
            end
        end
        chk("resp_mem_req", mem_req, 1'b0);
        chk("resp_busy", busy, 1'b1);
        chk("resp_no_ack", {30'h0, if_ack, dm_ack}, 32'h0);
        if (aborted) begin
            exp_rdata = 32'h0;
            m_bus_err = 1'b1;
        end else if (exp_we) begin
            exp_rdata = m_dm_rdata;
        end else begin
            exp_rdata = rd;
        end
        if (win_dm) m_dm_rdata = exp_rdata;
        else        m_if_rdata = exp_rdata;
        tick();
        chk("ack_if", if_ack, !win_dm);
        chk("ack_dm", dm_ack, win_dm);
        chk("ack_if_rdata", if_rdata, m_if_rdata);
        chk("ack_dm_rdata", dm_rdata, m_dm_rdata);
        chk("ack_bus_err", bus_err, m_bus_err);
        chk("ack_busy", busy, 1'b0);
        m_last_dm = win_dm;
        if (win_dm) dm_req = 1'b0;
        else        if_req = 1'b0;
    endtask

    task automatic raise_if();
        if_addr = {$urandom} & 32'hFFFF_FFFC;
        if_req  = 1'b1;
    endtask

    task automatic raise_dm();
        dm_we    = 1'($urandom_range(0, 1));
        dm_be    = 4'($urandom);
        dm_addr  = $urandom;
        dm_wdata = $urandom;
        dm_req   = 1'b1;
    endtask

    initial begin
        if_addr  = 32'h0;
        dm_we    = 1'b0;
        dm_be    = 4'h0;
        dm_addr  = 32'h0;
        dm_wdata = 32'h0;

        // Reset values
        do_reset();
        idle_checks("reset");
        chk("reset_mem_addr", mem_addr, 32'h0);
        chk("reset_mem_we", mem_we, 1'b0);
        chk("reset_mem_be", mem_be, 32'h0);
        chk("reset_mem_wdata", mem_wdata, 32'h0);

        // Single fetch, zero-wait memory
        if_addr = 32'h3000;
        if_req  = 1'b1;
        access(0, 32'h3C01_0001);
        chk("fetch_word", if_rdata, 32'h3C01_0001);
        tick();
        idle_checks("fetch_after");

        // Store with wait states: mem_req held for 3 cycles
        dm_we    = 1'b1;
        dm_be    = 4'b0011;
        dm_addr  = 32'h0004;
        dm_wdata = 32'h1234_5678;
        dm_req   = 1'b1;
        access(2, $urandom);
        tick();
        idle_checks("store_after");

        // Simultaneous requests from reset alternate, DATA first
        do_reset();
        raise_if();
        raise_dm();
        dm_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            access($urandom_range(0, 4), $urandom);
            if (!dm_req) begin
                raise_dm();
            end else begin
                raise_if();
            end
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        tick();
        tick();
        idle_checks("tie_after");

        // Timeout abort, then bus_err stays sticky
        dm_we   = 1'b0;
        dm_addr = 32'h0000_0100;
        dm_req  = 1'b1;
        access(TIMEOUT + 5, $urandom);
        chk("timeout_rdata", dm_rdata, 32'h0);
        chk("timeout_bus_err", bus_err, 1'b1);
        raise_if();
        access(1, $urandom);
        raise_dm();
        access(0, $urandom);
        chk("bus_err_sticky", bus_err, 1'b1);

        // Reset during the second DATA cycle
        tick();
        dm_we   = 1'b0;
        dm_addr = 32'h0000_0200;
        dm_req  = 1'b1;
        tick();
        tick();
        chk("midreset_mem_req_before", mem_req, 1'b1);
        reset  = 1'b1;
        dm_req = 1'b0;
        tick();
        reset = 1'b0;
        model_reset();
        chk("midreset_mem_req", mem_req, 1'b0);
        chk("midreset_busy", busy, 1'b0);
        chk("midreset_bus_err", bus_err, 1'b0);
        mem_ready = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ready = 1'b0;
        idle_checks("late_ready");
        tick();
        idle_checks("late_ready2");
        raise_if();
        access(1, $urandom);

        // Stray mem_ready in IDLE
        tick();
        mem_ready = 1'b1;
        mem_rdata = $urandom;
        tick();
        mem_ready = 1'b0;
        idle_checks("stray");
        tick();
        idle_checks("stray2");

        // Randomized traffic
        for (int i = 0; i < 24; i++) begin
            if (!if_req && !dm_req) begin
                case ($urandom_range(1, 3))
                    1: raise_if();
                    2: raise_dm();
                    default: begin
                        raise_if();
                        raise_dm();
                    end
                endcase
            end else if ($urandom_range(0, 1) == 1) begin
                if (!if_req) raise_if();
                else         raise_dm();
            end
            access(($urandom_range(0, 7) == 0) ? int'(TIMEOUT) + 1 : int'($urandom_range(0, 5)),
                   $urandom);
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        tick();
        idle_checks("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
